// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: one outstanding imem request, one-entry skid buffer, redirect handling
// Define IF_DELAY_SLOT_EN to deliver one sequential instruction after a taken branch before the target.
module if_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

`ifdef IF_DELAY_SLOT_EN
    localparam logic DELAY_SLOT = 1'b1;
`else
    localparam logic DELAY_SLOT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] tgt_q, tgt_d;
    logic        keep_q, keep_d;

    logic        ack;
    logic        consume;
    logic        take;
    logic [31:0] target;

    assign ack     = req_q & imem_ack_i;
    assign consume = valid_q & ~stall_i;
    assign take    = consume & branch_flag_i;
    assign target  = branch_target_i & 32'hFFFF_FFFC;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        valid_d    = valid_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        tgt_d      = tgt_q;
        keep_d     = keep_q;

        if (consume) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_FETCH: begin
                if (take) begin
                    if (ack) begin
                        // The word landing now is branch PC+4: the delay slot, or stale.
                        if (DELAY_SLOT) begin
                            pc_d    = addr_q;
                            inst_d  = imem_rdata_i;
                            valid_d = 1'b1;
                        end
                        addr_d = target;
                        req_d  = 1'b1;
                    end else if (req_q) begin
                        // Issued requests cannot be cancelled; park the target until the ack.
                        state_d = S_WAIT;
                        tgt_d   = target;
                        keep_d  = DELAY_SLOT;
                    end else begin
                        addr_d = target;
                        req_d  = 1'b1;
                    end
                end else begin
                    req_d = 1'b1;
                    if (ack) begin
                        addr_d = addr_q + 32'd4;
                        if (!valid_q || !stall_i) begin
                            pc_d    = addr_q;
                            inst_d  = imem_rdata_i;
                            valid_d = 1'b1;
                        end else begin
                            buf_pc_d   = addr_q;
                            buf_inst_d = imem_rdata_i;
                            req_d      = 1'b0;
                            state_d    = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    pc_d    = buf_pc_q;
                    inst_d  = buf_inst_q;
                    valid_d = 1'b1;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                    if (take) begin
                        if (!DELAY_SLOT) begin
                            valid_d = 1'b0;
                        end
                        addr_d = target;
                    end
                end
            end
            S_WAIT: begin
                if (ack) begin
                    if (keep_q) begin
                        pc_d    = addr_q;
                        inst_d  = imem_rdata_i;
                        valid_d = 1'b1;
                    end
                    addr_d  = tgt_q;
                    req_d   = 1'b1;
                    keep_d  = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            req_q      <= 1'b0;
            addr_q     <= 32'h0;
            pc_q       <= 32'h0;
            inst_q     <= 32'h0;
            valid_q    <= 1'b0;
            buf_pc_q   <= 32'h0;
            buf_inst_q <= 32'h0;
            tgt_q      <= 32'h0;
            keep_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
            tgt_q      <= tgt_d;
            keep_q     <= keep_d;
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign pc_o        = pc_q;
    assign inst_o      = inst_q;
    assign valid_o     = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized bench for if_stage against an instruction-stream model, plus directed timing checks
module tb_if_stage;

`ifdef IF_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;

    always #5 clk = ~clk;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_rdata_i   (imem_rdata_i),
        .pc_o           (pc_o),
        .inst_o         (inst_o),
        .valid_o        (valid_o)
    );

    int total = 0;
    int bad   = 0;
    int ack_pct = 100;
    int consumed = 0;

    // Reference: the architectural instruction stream the ID stage must see.
    logic [31:0] exp_pc    = 32'h0;
    logic        slot_pend = 1'b0;
    logic [31:0] slot_tgt  = 32'h0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc   = 32'h0;
    logic [31:0] prev_inst = 32'h0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA500_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [31:0] t;
        if (!rst) begin
            exp_pc    = 32'h0;
            slot_pend = 1'b0;
            prev_pend = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (prev_pend) begin
                chk("req_held", {31'b0, imem_req_o}, 32'd1);
                chk("addr_stable", imem_addr_o, prev_addr);
            end
            if (imem_req_o) begin
                chk("addr_aligned", {30'b0, imem_addr_o[1:0]}, 32'd0);
            end
            if (prev_hold) begin
                chk("hold_valid", {31'b0, valid_o}, 32'd1);
                chk("hold_pc", pc_o, prev_pc);
                chk("hold_inst", inst_o, prev_inst);
            end
            if (valid_o && !stall_i) begin
                chk("stream_pc", pc_o, exp_pc);
                chk("stream_inst", inst_o, memf(exp_pc));
                consumed++;
                if (branch_flag_i) begin
                    t = branch_target_i & 32'hFFFF_FFFC;
                    if (DS) begin
                        exp_pc    = slot_pend ? slot_tgt : exp_pc + 32'd4;
                        slot_tgt  = t;
                        slot_pend = 1'b1;
                    end else begin
                        exp_pc = t;
                    end
                end else if (slot_pend) begin
                    exp_pc    = slot_tgt;
                    slot_pend = 1'b0;
                end else begin
                    exp_pc = exp_pc + 32'd4;
                end
            end
            prev_pend = imem_req_o && !imem_ack_i;
            prev_addr = imem_addr_o;
            prev_hold = valid_o && stall_i;
            prev_pc   = pc_o;
            prev_inst = inst_o;
        end
    endtask

    // Check the cycle at negedge, then advance one edge and answer memory.
    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #2;
        imem_ack_i   = imem_req_o && ($urandom_range(99) < ack_pct);
        imem_rdata_i = memf(imem_addr_o);
    endtask

    task automatic chk_out(input string name, input logic [31:0] pc, input logic v,
                           input logic req, input logic [31:0] addr);
        chk({name, "_pc"}, pc_o, pc);
        chk({name, "_valid"}, {31'b0, valid_o}, {31'b0, v});
        chk({name, "_req"}, {31'b0, imem_req_o}, {31'b0, req});
        chk({name, "_addr"}, imem_addr_o, addr);
    endtask

    initial begin
        repeat (3) step();
        chk_out("reset", 32'h0, 1'b0, 1'b0, 32'h0);
        chk("reset_inst", inst_o, 32'h0);

        rst = 1'b1;
        step();
        chk_out("first_req", 32'h0, 1'b0, 1'b1, 32'h0);
        step();
        chk_out("seq0", 32'h0, 1'b1, 1'b1, 32'h4);
        chk("seq0_inst", inst_o, 32'hA500_0000);
        step();
        chk_out("seq4", 32'h4, 1'b1, 1'b1, 32'h8);
        step();
        chk_out("seq8", 32'h8, 1'b1, 1'b1, 32'hC);

        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("stall", 32'h8, 1'b1, 1'b0, 32'h10);
        end
        stall_i = 1'b0;
        step();
        chk_out("release_c", 32'hC, 1'b1, 1'b1, 32'h10);
        chk("release_c_inst", inst_o, 32'hA500_000C);
        step();
        chk_out("release_10", 32'h10, 1'b1, 1'b1, 32'h14);

        branch_flag_i   = 1'b1;
        branch_target_i = 32'h103;
        step();
        branch_flag_i = 1'b0;
`ifdef IF_DELAY_SLOT_EN
        chk_out("br_slot", 32'h14, 1'b1, 1'b1, 32'h100);
`else
        chk_out("br_noslot", 32'h10, 1'b0, 1'b1, 32'h100);
`endif
        step();
        chk_out("br_target", 32'h100, 1'b1, 1'b1, 32'h104);

        ack_pct         = 0;
        imem_ack_i      = 1'b0;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h200;
        step();
        branch_flag_i = 1'b0;
        chk_out("wait0", 32'h100, 1'b0, 1'b1, 32'h104);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("wait", 32'h100, 1'b0, 1'b1, 32'h104);
        end
        ack_pct    = 100;
        imem_ack_i = 1'b1;
        step();
`ifdef IF_DELAY_SLOT_EN
        chk_out("wait_done", 32'h104, 1'b1, 1'b1, 32'h200);
`else
        chk_out("wait_done", 32'h100, 1'b0, 1'b1, 32'h200);
`endif
        step();
        chk_out("tgt200", 32'h200, 1'b1, 1'b1, 32'h204);

        branch_flag_i   = 1'b1;
        branch_target_i = 32'hFFFF_FFFE;
        step();
        branch_flag_i = 1'b0;
        chk("wrap_req_addr", imem_addr_o, 32'hFFFF_FFFC);
        step();
        chk_out("wrap", 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0);
        step();
        chk_out("wrap0", 32'h0, 1'b1, 1'b1, 32'h4);

        branch_flag_i   = 1'b1;
        branch_target_i = 32'h40;
        step();
        branch_flag_i = 1'b0;
        ack_pct       = 0;
        imem_ack_i    = 1'b0;
        chk("rst_mid_addr", imem_addr_o, 32'h40);
        step();
        rst = 1'b0;
        step();
        chk_out("rst_mid", 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rst_mid_inst", inst_o, 32'h0);
        rst     = 1'b1;
        ack_pct = 100;
        step();
        chk_out("rst_restart", 32'h0, 1'b0, 1'b1, 32'h0);

        ack_pct = 60;
        for (int i = 0; i < 4000; i++) begin
            step();
            stall_i         = ($urandom_range(9) < 3);
            branch_flag_i   = ($urandom_range(7) == 0);
            branch_target_i = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(15))
                                                       : $urandom;
            rst             = ($urandom_range(499) != 0);
        end
        rst           = 1'b1;
        stall_i       = 1'b0;
        branch_flag_i = 1'b0;
        step();
        chk("liveness", {31'b0, consumed > 800}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
